// File: rtl/proc_network_interface.sv
`default_nettype none
// ============================================================================
// Module   : proc_network_interface
// Purpose  : Clocked endpoint between a synchronous processing element and a
//            router processor port. TX packs {dst_x, dst_y, payload} into a
//            flit and injects it over a 2-phase bundled-data req/ack channel.
//            RX accepts flits from the router over the same protocol and
//            presents them as a one-entry valid/ready stream. The asynchronous
//            handshake inputs (out_ack, in_req) are synchronized into clk.
// Ports    : clk, rst (async, active-low)
//            tx_valid/tx_ready/tx_dst_x/tx_dst_y/tx_payload : core -> TX
//            out_req/out_ack/out_data                       : TX -> router
//            in_req/in_ack/in_data                          : router -> RX
//            rx_valid/rx_ready/rx_data/rx_misroute          : RX -> core
// Params   : n (flit width, must exceed maxx+maxy), maxx, maxy (header field
//            widths), srcx, srcy (this node), SYNC_STAGES (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module proc_network_interface #(
   parameter int n           = 32,
   parameter int maxx        = 1,
   parameter int maxy        = 1,
   parameter int srcx        = 0,
   parameter int srcy        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   // core transmit stream
   input  logic                   tx_valid,
   output logic                   tx_ready,
   input  logic [maxx-1:0]        tx_dst_x,
   input  logic [maxy-1:0]        tx_dst_y,
   input  logic [n-maxx-maxy-1:0] tx_payload,
   // 2-phase channel to router processor input
   output logic                   out_req,
   input  logic                   out_ack,
   output logic [n-1:0]           out_data,
   // 2-phase channel from router processor output
   input  logic                   in_req,
   output logic                   in_ack,
   input  logic [n-1:0]           in_data,
   // core receive stream
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic [n-1:0]           rx_data,
   output logic                   rx_misroute
);

   localparam logic [maxx-1:0] c_src_x = maxx'(srcx);
   localparam logic [maxy-1:0] c_src_y = maxy'(srcy);

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_LOAD = 2'd1,
      TX_WAIT = 2'd2
   } tx_state_t;

   // ------------------------------------------------------------------------
   // Handshake synchronizers: shift toward the MSB, use the last stage only.
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic [SYNC_STAGES-1:0] r_req_sync;
   logic                   w_ack_s;
   logic                   w_req_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ack_sync <= '0;
         r_req_sync <= '0;
      end else begin
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], out_ack};
         r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], in_req};
      end
   end

   assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
   assign w_req_s = r_req_sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------------
   // TX FSM. Data is loaded one state before req toggles so the bundled data
   // is settled for a full cycle ahead of the request edge.
   // ------------------------------------------------------------------------
   tx_state_t r_tx_state;
   tx_state_t w_tx_state_next;
   logic      w_load;
   logic      w_toggle;

   always_comb begin
      w_tx_state_next = r_tx_state;
      w_load          = 1'b0;
      w_toggle        = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            if (tx_valid && tx_ready) begin
               w_load          = 1'b1;
               w_tx_state_next = TX_LOAD;
            end
         end
         TX_LOAD: begin
            w_toggle        = 1'b1;
            w_tx_state_next = TX_WAIT;
         end
         TX_WAIT: begin
            // phases match again once the router has acknowledged
            if (w_ack_s == out_req)
               w_tx_state_next = TX_IDLE;
         end
         default: w_tx_state_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_state <= TX_IDLE;
         tx_ready   <= 1'b1;
         out_req    <= 1'b0;
         out_data   <= '0;
      end else begin
         r_tx_state <= w_tx_state_next;
         // registered from the next state: no path from tx_valid to tx_ready
         tx_ready   <= (w_tx_state_next == TX_IDLE);
         if (w_load)
            out_data <= {tx_dst_x, tx_dst_y, tx_payload};
         if (w_toggle)
            out_req <= ~out_req;
      end
   end

   // ------------------------------------------------------------------------
   // RX slot. A pending transfer is captured when the slot is empty or is
   // being consumed on this same edge; acking on the capture edge releases
   // the router, which otherwise holds in_data stable.
   // ------------------------------------------------------------------------
   logic w_pending;
   logic w_free;
   logic w_capture;
   logic w_hdr_bad;

   assign w_pending = (w_req_s != in_ack);
   assign w_free    = !rx_valid || rx_ready;
   assign w_capture = w_pending && w_free;
   assign w_hdr_bad = (in_data[n-1 -: maxx] != c_src_x) ||
                      (in_data[n-maxx-1 -: maxy] != c_src_y);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ack      <= 1'b0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         rx_misroute <= 1'b0;
      end else begin
         if (w_capture) begin
            rx_data  <= in_data;
            rx_valid <= 1'b1;
            in_ack   <= ~in_ack;
            if (w_hdr_bad)
               rx_misroute <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
